// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM duty decoder and its generator-side
// counterpart: FSM state encoding, stuck codes and the PWM period length.
package pwm_capture_pkg;

  localparam int PWM_STEPS = 256;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    CHECK   = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    STUCK_NONE = 2'b00,
    STUCK_LOW  = 2'b01,
    STUCK_HIGH = 2'b10
  } stuck_e;

endpackage

// File: rtl/pwm_capture_tick_gen.sv
// Free-running prescaler: emits a one-clock tick every DIV_COUNT clocks,
// on the last count of each cycle.
module tick_gen #(
  parameter int DIV_COUNT = 188
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM duty decoder: measures high ticks over a 256-tick window aligned to the
// input's rising edge and republishes the generator's 8-bit duty code.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int DIV_COUNT  = 188,
  parameter int HUNT_TICKS = 512
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic       valid,
  output logic       locked,
  output logic [1:0] stuck,
  output logic       changed
);
  localparam int HW = (HUNT_TICKS > 1) ? $clog2(HUNT_TICKS) : 1;
  localparam logic [HW-1:0] HUNT_LAST = HW'(HUNT_TICKS - 1);
  localparam logic [7:0] WIN_LAST = 8'(PWM_STEPS - 1);

  // Generator high time is duty+1 ticks; a full-high window saturates at FF.
  function automatic logic [7:0] decode_duty(input logic [8:0] high_cnt);
    if (high_cnt == 9'd0) return 8'h00;
    return 8'(high_cnt - 9'd1);
  endfunction

  logic          tick;
  logic          sync_p0_q, s_q;
  logic          prev_q, prev_d;
  cap_state_e    state_q, state_d;
  logic [HW-1:0] hunt_q, hunt_d;
  logic [7:0]    win_q, win_d;
  logic [8:0]    high_q, high_d;
  logic [8:0]    high_total;
  logic [7:0]    duty_q, duty_d;
  stuck_e        stuck_q, stuck_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic          locked_q, locked_d;
  logic          rise;
  logic          pub;
  logic [7:0]    pub_duty;
  stuck_e        pub_stuck;

  tick_gen #(
    .DIV_COUNT(DIV_COUNT)
  ) u_tick_gen (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .tick_o(tick)
  );

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0_q <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      sync_p0_q <= pwm_in;
      s_q       <= sync_p0_q;
    end
  end

  assign rise       = tick & s_q & ~prev_q;
  assign high_total = high_q + {8'd0, s_q};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    hunt_d    = hunt_q;
    win_d     = win_q;
    high_d    = high_q;
    locked_d  = locked_q;
    duty_d    = duty_q;
    stuck_d   = stuck_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    pub       = 1'b0;
    pub_duty  = 8'h00;
    pub_stuck = STUCK_NONE;

    if (tick) begin
      prev_d = s_q;
      unique case (state_q)
        HUNT: begin
          if (rise) begin
            state_d = MEASURE;
            hunt_d  = '0;
            win_d   = 8'd1;
            high_d  = 9'd1;
          end else if (hunt_q == HUNT_LAST) begin
            hunt_d    = '0;
            locked_d  = 1'b0;
            pub       = 1'b1;
            pub_duty  = s_q ? 8'hFF : 8'h00;
            pub_stuck = s_q ? STUCK_HIGH : STUCK_LOW;
          end else begin
            hunt_d = hunt_q + HW'(1);
          end
        end
        MEASURE: begin
          if (win_q == WIN_LAST) begin
            pub      = 1'b1;
            pub_duty = decode_duty(high_total);
            state_d  = CHECK;
          end else begin
            win_d  = win_q + 8'd1;
            high_d = high_total;
          end
        end
        CHECK: begin
          // A back-to-back edge keeps the windows aligned without re-hunting
          if (rise) begin
            locked_d = 1'b1;
            state_d  = MEASURE;
            win_d    = 8'd1;
            high_d   = 9'd1;
          end else begin
            locked_d = 1'b0;
            state_d  = HUNT;
            hunt_d   = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (pub) begin
      valid_d   = 1'b1;
      duty_d    = pub_duty;
      stuck_d   = pub_stuck;
      changed_d = (pub_duty != duty_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= HUNT;
      prev_q    <= 1'b0;
      hunt_q    <= '0;
      win_q     <= 8'd0;
      high_q    <= 9'd0;
      locked_q  <= 1'b0;
      duty_q    <= 8'h00;
      stuck_q   <= STUCK_NONE;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      hunt_q    <= hunt_d;
      win_q     <= win_d;
      high_q    <= high_d;
      locked_q  <= locked_d;
      duty_q    <= duty_d;
      stuck_q   <= stuck_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign duty    = duty_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign stuck   = stuck_q;
  assign changed = changed_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the board's 8-bit PWM LED driver: samples an external PWM input and recovers its 8-bit duty value. It uses the same prescaled sample tick and 256-step period as the generator, so a generator-produced waveform decodes back to its own duty code. It sits between an input pin (or loop-back of a generator output) and any logic that needs the measured brightness or duty.

## Interface
- DIV_COUNT, 188, CLK cycles per sample tick; must equal the generator's prescaler (8-bit period at ~1 kHz from 48 MHz).
- HUNT_TICKS, 512, ticks to wait for a rising edge before declaring a stuck input.
- CLK  in  1  system clock, 48 MHz.
- RST_N  in  1  reset; **one clock; reset is asynchronous and active-low**.
- pwm_in  in  1  asynchronous PWM input, active-high.
- duty  out  8  last decoded duty code.
- valid  out  1  one-CLK pulse when duty/stuck are updated.
- locked  out  1  high while windows are aligned to input rising edges.
- stuck  out  2  00 none, 01 stuck low, 10 stuck high; updated with valid.
- changed  out  1  one-CLK pulse, coincident with valid, when new duty differs from the previous duty.

## Operation
- 2-flop synchronizer on pwm_in, reset to 0; all logic uses the synchronized signal s.
- Prescaler: 0..DIV_COUNT-1 free-running counter; tick is 1 CLK wide when the count equals DIV_COUNT-1.
- Sampling and edge detection occur only on tick cycles; prev holds s from the previous tick. A rising edge is prev=0, s=1.
- FSM states:
  - HUNT: the hunt counter counts ticks.
    - Rising edge: go to MEASURE, clear the window and high counters, count this tick as sample 0 (high).
    - Hunt counter reaches HUNT_TICKS-1 with no edge: publish duty=00 and stuck=01 if s=0; publish duty=FF and stuck=10 if s=1. Clear locked, restart hunting.
  - MEASURE: 8-bit window counter counts 256 ticks; a 9-bit high counter adds s at each tick.
    - After tick 255: publish, go to CHECK.
  - CHECK: lasts one tick slot, the tick immediately after the window.
    - Rising edge: set locked, re-enter MEASURE as a new sample 0.
    - No rising edge: clear locked, go to HUNT.
- Decode rule, matching generator high-time = duty+1 ticks:
  - duty = high_count-1.
  - high_count 0 cannot occur in MEASURE, because sample 0 is high.
  - high_count 256 gives FF.
  - stuck=00 when publishing from MEASURE.
- changed compares against the previously published duty, including HUNT-timeout publishes.

## Timing
- Reset values:
  - duty=00, valid=0, locked=0, stuck=00, changed=0.
  - FSM=HUNT; all counters 0; prev=0.
- Input to s latency: 2 CLK.
- valid asserts the CLK cycle after the tick that completed sample 255. The same applies to a HUNT timeout.
- duty and stuck are registered and hold until the next valid.
- First valid after lock arrives 256 ticks after the first detected rising edge.
- Steady state: one valid per 256 ticks when the input period is 256 ticks.
  - Generator-to-decoder phase offset does not affect duty, because windows start on the input edge.
- Input period ≠ 256 ticks: locked drops at CHECK, and the next window re-aligns from HUNT.
- Async reset mid-window: all state clears immediately; no valid is emitted for the partial window.

## Structure
- Shared package holds:
  - FSM state enum (HUNT, MEASURE, CHECK).
  - Stuck codes: STUCK_NONE, STUCK_LOW, STUCK_HIGH.
  - PWM_STEPS=256.
- One sub-module: tick_gen, the parameterized prescaler emitting a 1-CLK tick. It is reusable by the generator side.
- The synchronizer is inline.

## Test plan
- Drive a generator-model waveform, duty 0x80, with a random initial phase -> valid every 256·188 CLK; duty=0x80, locked=1 from the second window on, stuck=00.
- Generator-model duty 0x00, then 0xFF -> duty 0x00, then 0xFF; changed pulses exactly once at the transition.
- pwm_in held 0 from reset -> after 512 ticks plus 1 CLK, valid with duty=00, stuck=01, locked=0; repeats every 512 ticks. pwm_in held 1 -> duty=FF, stuck=10.
- Input period 300 ticks -> locked never stays high; no valid with stuck=00 at a CHECK boundary without a rising edge; re-hunt observed.
- Assert RST_N low mid-MEASURE -> all outputs return to reset values in the same cycle. After release, the next valid comes only after a full fresh window.
- Glitch narrower than 1 tick between samples on a 0x40 waveform -> duty remains 0x40 ±1, and no spurious valid is emitted.
